datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (16-bit instruction, 8 registers).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  instruction-valid request; sampled only in WAIT.
REQ-005 instr  in  16  instruction; captured on the accepting edge.
REQ-006 busy  out  1  high in every non-WAIT state.
REQ-007 done  out  1  one-cycle completion pulse.
REQ-008 illegal  out  1  one-cycle pulse, coincident with done, when the opcode is undefined.
REQ-009 readnum  out  3  register-file read select.
REQ-010 writenum  out  3  register-file write select.
REQ-011 write  out  1  register-file write strobe.
REQ-012 vsel  out  1  write-data select; 1 = datapath_in, 0 = C.
REQ-013 loada, loadb  out  1 each  A/B pipeline register load strobes.
REQ-014 asel  out  1  1 = force ALU A operand to 0.
REQ-015 bsel  out  1  B-operand source select; held 0 (shifted B) in every state.
REQ-016 shift  out  2  shifter control.
REQ-017 ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B.
REQ-018 loadc, loads  out  1 each  C register and status flag load strobes.
REQ-019 datapath_in  out  16  registered sign-extension of captured instr[7:0].

Function
REQ-020 Fields of the captured instruction: opc = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], imm8 = [7:0].
REQ-021 Moore FSM with states WAIT, DECODE, GETA, GETB, ALU, WREG and WIMM; the state-to-output decode uses only the state and the captured fields.
REQ-022 Acceptance: start=1 in WAIT captures instr and datapath_in and moves to DECODE; start is ignored in every other state.
REQ-023 DECODE drives no strobes and branches to the first state of the decoded sequence below.
REQ-024 MOV imm (110/10): sequence DECODE, WIMM; WIMM drives writenum=Rn, vsel=1, write=1.
REQ-025 MOV reg (110/00) and MVN (101/11): sequence DECODE, GETB, ALU, WREG; ALUop=00 for MOV and 11 for MVN.
REQ-026 ADD (101/00) and AND (101/10): sequence DECODE, GETA, GETB, ALU, WREG; ALUop=00 for ADD and 10 for AND.
REQ-027 CMP (101/01): sequence DECODE, GETA, GETB, ALU with ALUop=01; ALU drives loads=1 and loadc=0; there is no WREG and no register write.
REQ-028 Common state actions:
  - GETA: readnum=Rn, loada=1.
  - GETB: readnum=Rm, loadb=1.
  - ALU: shift=sh, asel=1 only for MOV/MVN, loadc=1 except for CMP; loads=1 for every ALU operation.
  - WREG: writenum=Rd, vsel=0, write=1.
REQ-029 Every strobe, shift, ALUop, asel, bsel and vsel is 0 in any state that does not name it; readnum and writenum are 0 when unused.
REQ-030 Any other opc/op pair: DECODE returns to WAIT with done=1 and illegal=1 and issues no strobes.
REQ-031 After the final action state the FSM returns to WAIT and done=1 for exactly that first WAIT cycle; a start in that same cycle is accepted.
REQ-032 Busy cycles per instruction: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, illegal 1.

Reset
REQ-033 While reset_n=0, regardless of state, the FSM enters WAIT; all outputs and the captured fields are 0; no write is issued; the in-flight instruction is discarded without a done pulse.

Verification
REQ-034 MOV imm: instr=16'hD2FE (MOV R2,#-2) -> WIMM with writenum=2, write=1, datapath_in=16'hFFFE, vsel=1; done in cycle 3 after acceptance.
REQ-035 ADD: instr=16'hA1A8 (ADD R5,R1,R0 LSL#1) -> readnum 1 then 0, shift=01 in ALU, writenum=5, write=1; busy for 5 cycles.
REQ-036 CMP: instr=16'hAB02 -> loads=1 and loadc=0 in ALU; write never asserted; done after 4 busy cycles.
REQ-037 Illegal: instr=16'hE000 -> done=1 and illegal=1 after 1 busy cycle; all strobes 0 throughout.
REQ-038 Interference: start pulsed during GETB is ignored; reset_n dropped during ALU forces WAIT with write=0; a back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore control FSM for a small 16-bit register/ALU datapath.
// Accepts one instruction per start pulse, captures it, and sequences the
// register-file reads, ALU operation and write-back. It then reports completion
// with a single done cycle back in WAIT.
module datapath_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] instr,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic [15:0] datapath_in
);

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GETA   = 3'd2,
      S_GETB   = 3'd3,
      S_ALU    = 3'd4,
      S_WREG   = 3'd5,
      S_WIMM   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      K_MOVI, K_MOVR, K_MVN, K_ADD, K_AND, K_CMP, K_ILL
   } kind_t;

   state_t      state, state_nxt;
   kind_t       kind;
   logic [15:0] ir;
   logic        done_nxt, illegal_nxt;

   // Field views of the captured instruction.
   logic [2:0] opc, rn, rd, rm;
   logic [1:0] op, sh;
   assign opc = ir[15:13];
   assign op  = ir[12:11];
   assign rn  = ir[10:8];
   assign rd  = ir[7:5];
   assign sh  = ir[4:3];
   assign rm  = ir[2:0];

   // Classify the captured opcode pair into an instruction kind.
   always_comb begin
      kind = K_ILL;
      unique case ({opc, op})
         5'b110_10: kind = K_MOVI;
         5'b110_00: kind = K_MOVR;
         5'b101_11: kind = K_MVN;
         5'b101_00: kind = K_ADD;
         5'b101_10: kind = K_AND;
         5'b101_01: kind = K_CMP;
         default:   kind = K_ILL;
      endcase
   end

   // Next-state logic and Moore output decode from state plus captured fields.
   always_comb begin
      // NOTE: every output is defaulted before the case so no path can leave
      // one unassigned; that is what keeps this block free of inferred latches.
      state_nxt   = state;
      done_nxt    = 1'b0;
      illegal_nxt = 1'b0;
      busy        = 1'b1;
      readnum     = 3'd0;
      writenum    = 3'd0;
      write       = 1'b0;
      vsel        = 1'b0;
      loada       = 1'b0;
      loadb       = 1'b0;
      asel        = 1'b0;
      bsel        = 1'b0;
      shift       = 2'b00;
      ALUop       = 2'b00;
      loadc       = 1'b0;
      loads       = 1'b0;
      unique case (state)
         S_WAIT: begin
            busy = 1'b0;
            if (start) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            unique case (kind)
               K_MOVI:        state_nxt = S_WIMM;
               K_MOVR, K_MVN: state_nxt = S_GETB;
               K_ILL: begin
                  state_nxt   = S_WAIT;
                  done_nxt    = 1'b1;
                  illegal_nxt = 1'b1;
               end
               default:       state_nxt = S_GETA;
            endcase
         end
         S_GETA: begin
            readnum   = rn;
            loada     = 1'b1;
            state_nxt = S_GETB;
         end
         S_GETB: begin
            readnum   = rm;
            loadb     = 1'b1;
            state_nxt = S_ALU;
         end
         S_ALU: begin
            shift = sh;
            loads = 1'b1;
            unique case (kind)
               K_MVN:   ALUop = 2'b11;
               K_AND:   ALUop = 2'b10;
               K_CMP:   ALUop = 2'b01;
               default: ALUop = 2'b00;
            endcase
            asel = (kind == K_MOVR) || (kind == K_MVN);
            if (kind == K_CMP) begin
               state_nxt = S_WAIT;
               done_nxt  = 1'b1;
            end else begin
               loadc     = 1'b1;
               state_nxt = S_WREG;
            end
         end
         S_WREG: begin
            writenum  = rd;
            write     = 1'b1;
            state_nxt = S_WAIT;
            done_nxt  = 1'b1;
         end
         S_WIMM: begin
            writenum  = rn;
            vsel      = 1'b1;
            write     = 1'b1;
            state_nxt = S_WAIT;
            done_nxt  = 1'b1;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = S_WAIT;
         end
      endcase
   end

   // State register and the one-cycle done/illegal pulses seen in WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_WAIT;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state   <= state_nxt;
         done    <= done_nxt;
         illegal <= illegal_nxt;
      end
   end

   // Capture the instruction and its sign-extended immediate on acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir          <= 16'h0000;
         datapath_in <= 16'h0000;
      end else if (state == S_WAIT && start) begin
         ir          <= instr;
         datapath_in <= {{8{instr[7]}}, instr[7:0]};
      end
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed bench for datapath_ctrl. Each issued instruction
// pushes its expected per-cycle output bundle into a queue; every cycle one
// entry is popped and compared against the sampled DUT outputs.
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] instr;
   logic        busy, done, illegal, write, vsel, loada, loadb, asel, bsel;
   logic        loadc, loads;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        illegal;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic        vsel;
      logic        loada;
      logic        loadb;
      logic        asel;
      logic        bsel;
      logic [1:0]  shift;
      logic [1:0]  aluop;
      logic        loadc;
      logic        loads;
      logic [15:0] dp;
   } out_t;

   out_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   busy_cnt;

   datapath_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
      .busy(busy), .done(done), .illegal(illegal),
      .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
      .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
      .datapath_in(datapath_in)
   );

   always #5 clk = ~clk;

   function automatic out_t observed();
      out_t o;
      o.busy = busy;   o.done = done;   o.illegal = illegal;
      o.readnum = readnum;   o.writenum = writenum;
      o.write = write; o.vsel = vsel;   o.loada = loada;   o.loadb = loadb;
      o.asel = asel;   o.bsel = bsel;   o.shift = shift;   o.aluop = ALUop;
      o.loadc = loadc; o.loads = loads; o.dp = datapath_in;
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Push the expected cycle-by-cycle outputs of one instruction, from the
   // DECODE cycle through the done cycle in WAIT.
   task automatic push_expect(input logic [15:0] i);
      logic [15:0] dp;
      logic [2:0]  opc, rn, rd, rm;
      logic [1:0]  op, sh;
      out_t base, e;
      dp  = {{8{i[7]}}, i[7:0]};
      opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5];
      sh  = i[4:3];   rm = i[2:0];
      base = '0; base.busy = 1'b1; base.dp = dp;
      exp_q.push_back(base);                                   // DECODE
      if (opc == 3'b110 && op == 2'b10) begin                  // MOV imm
         e = base; e.writenum = rn; e.vsel = 1'b1; e.write = 1'b1;
         exp_q.push_back(e);
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101)) begin
         if (opc == 3'b101 && op != 2'b11) begin               // GETA
            e = base; e.readnum = rn; e.loada = 1'b1; exp_q.push_back(e);
         end
         e = base; e.readnum = rm; e.loadb = 1'b1; exp_q.push_back(e);
         e = base; e.shift = sh; e.loads = 1'b1;               // ALU
         if (opc == 3'b110)      begin e.aluop = 2'b00; e.asel = 1'b1; e.loadc = 1'b1; end
         else if (op == 2'b11)   begin e.aluop = 2'b11; e.asel = 1'b1; e.loadc = 1'b1; end
         else if (op == 2'b10)   begin e.aluop = 2'b10; e.loadc = 1'b1; end
         else if (op == 2'b01)   begin e.aluop = 2'b01; end
         else                    begin e.aluop = 2'b00; e.loadc = 1'b1; end
         exp_q.push_back(e);
         if (!(opc == 3'b101 && op == 2'b01)) begin            // WREG
            e = base; e.writenum = rd; e.write = 1'b1; exp_q.push_back(e);
         end
      end
      e = '0; e.dp = dp; e.done = 1'b1;                        // done cycle
      e.illegal = !((opc == 3'b110 && (op == 2'b10 || op == 2'b00)) || opc == 3'b101);
      exp_q.push_back(e);
   endtask

   // Advance one clock; start is a single-edge request so drop it after the edge.
   task automatic do_cycle(input string tag);
      out_t e;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      if (busy) busy_cnt++;
      check(tag, observed(), e);
   endtask

   // Called at a negedge: present an instruction for the next edge.
   task automatic issue(input logic [15:0] i);
      start = 1'b1;
      instr = i;
      busy_cnt = 0;
      push_expect(i);
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) do_cycle(tag);
   endtask

   task automatic idle_cycle(input logic [15:0] dp);
      out_t e;
      e = '0; e.dp = dp;
      exp_q.push_back(e);
      do_cycle("idle");
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      instr   = 16'h0000;
      repeat (2) @(negedge clk);
      check("reset_outputs", observed(), 64'd0);
      reset_n = 1'b1;
      idle_cycle(16'h0000);

      // MOV R2,#-2: two busy cycles, done on the third cycle after acceptance.
      issue(16'hD2FE);
      drain("movi");
      check("movi_busy_cycles", 64'(busy_cnt), 64'd2);
      idle_cycle(16'hFFFE);

      // ADD R5,R1,R0 LSL#1: five busy cycles.
      issue(16'hA1A8);
      drain("add");
      check("add_busy_cycles", 64'(busy_cnt), 64'd5);

      // CMP issued back-to-back in the ADD done cycle.
      issue(16'hAB02);
      drain("cmp");
      check("cmp_busy_cycles", 64'(busy_cnt), 64'd4);

      // Illegal opcode back-to-back.
      issue(16'hE000);
      drain("illegal");
      check("ill_busy_cycles", 64'(busy_cnt), 64'd1);
      idle_cycle(16'h0000);

      // MOV reg, MVN, AND with assorted registers and shifts.
      issue(16'hC0F5);  drain("movr");
      check("movr_busy_cycles", 64'(busy_cnt), 64'd4);
      issue(16'hB84E);  drain("mvn");
      check("mvn_busy_cycles", 64'(busy_cnt), 64'd4);
      issue(16'hB6F3);  drain("and");
      issue(16'hC800);  drain("illegal_110_01");

      // start pulsed during GETB must be ignored.
      idle_cycle(16'h0000);
      issue(16'hA1A8);
      do_cycle("gb_decode");
      do_cycle("gb_geta");
      do_cycle("gb_getb");
      start = 1'b1;
      instr = 16'hE07F;
      drain("gb_rest");

      // Reset asserted during ALU forces WAIT, no write, no done.
      idle_cycle(16'hFFA8);
      issue(16'hA1A8);
      do_cycle("rst_decode");
      do_cycle("rst_geta");
      do_cycle("rst_getb");
      do_cycle("rst_alu");
      exp_q.delete();
      reset_n = 1'b0;
      #1;
      check("rst_async_outputs", observed(), 64'd0);
      @(negedge clk);
      check("rst_held_outputs", observed(), 64'd0);
      reset_n = 1'b1;
      idle_cycle(16'h0000);
      idle_cycle(16'h0000);

      // Operation after reset recovery.
      issue(16'hD57F);
      drain("movi_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
